// File: rtl/risc_id_ex_stage.sv
// rtl/risc_id_ex_stage.sv - ID/EX pipeline register with MEM/WB operand forwarding and branch resolution
module risc_id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [RA_W-1:0] Rs1D,
    input  logic [RA_W-1:0] Rs2D,
    input  logic [RA_W-1:0] RdD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            AluSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      AluControlD,
    input  logic [XLEN-1:0] AluResultM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [RA_W-1:0] RdM,
    input  logic [RA_W-1:0] RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            ZeroE,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [2:0]      AluControlE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [RA_W-1:0] RdE,
    output logic [RA_W-1:0] Rs1E,
    output logic [RA_W-1:0] Rs2E,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            PCSrcE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            ValidE
);

    logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d, pc_q, pc_d, pc4_q, pc4_d, imm_q, imm_d;
    logic [RA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic            rw_q, rw_d, mw_q, mw_d, jump_q, jump_d, br_q, br_d;
    logic            alusrc_q, alusrc_d, valid_q, valid_d;
    logic [1:0]      rsrc_q, rsrc_d;
    logic [2:0]      aluc_q, aluc_d;

    // Flush only clears what can cause architectural effect; data words may go stale.
    always_comb begin
        rd1_d = rd1_q;   rd2_d = rd2_q;   pc_d = pc_q;   pc4_d = pc4_q;   imm_d = imm_q;
        rs1_d = rs1_q;   rs2_d = rs2_q;   rd_d = rd_q;
        rw_d = rw_q;     mw_d = mw_q;     jump_d = jump_q;   br_d = br_q;
        alusrc_d = alusrc_q;  valid_d = valid_q;  rsrc_d = rsrc_q;  aluc_d = aluc_q;
        if (flush_e) begin
            rw_d = 1'b0;   mw_d = 1'b0;   jump_d = 1'b0;   br_d = 1'b0;   valid_d = 1'b0;
            rsrc_d = '0;   aluc_d = '0;   rs1_d = '0;      rs2_d = '0;    rd_d = '0;
        end else if (!stall_e) begin
            rd1_d = RD1D;  rd2_d = RD2D;  pc_d = PCD;      pc4_d = PCPlus4D;  imm_d = ImmExtD;
            rs1_d = Rs1D;  rs2_d = Rs2D;  rd_d = RdD;
            rw_d = RegWriteD;  mw_d = MemWriteD;  jump_d = JumpD;  br_d = BranchD;
            alusrc_d = AluSrcD;  rsrc_d = ResultSrcD;  aluc_d = AluControlD;  valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q <= '0;  rd2_q <= '0;  pc_q <= '0;  pc4_q <= '0;  imm_q <= '0;
            rs1_q <= '0;  rs2_q <= '0;  rd_q <= '0;
            rw_q <= 1'b0;  mw_q <= 1'b0;  jump_q <= 1'b0;  br_q <= 1'b0;
            alusrc_q <= 1'b0;  valid_q <= 1'b0;  rsrc_q <= '0;  aluc_q <= '0;
        end else begin
            rd1_q <= rd1_d;  rd2_q <= rd2_d;  pc_q <= pc_d;  pc4_q <= pc4_d;  imm_q <= imm_d;
            rs1_q <= rs1_d;  rs2_q <= rs2_d;  rd_q <= rd_d;
            rw_q <= rw_d;  mw_q <= mw_d;  jump_q <= jump_d;  br_q <= br_d;
            alusrc_q <= alusrc_d;  valid_q <= valid_d;  rsrc_q <= rsrc_d;  aluc_q <= aluc_d;
        end
    end

    // MEM beats WB because it holds the younger write; x0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                           input logic rw_m, input logic [RA_W-1:0] rd_m,
                                           input logic rw_w, input logic [RA_W-1:0] rd_w);
        if (rw_m && (rd_m != '0) && (rd_m == rs))
            return 2'b10;
        else if (rw_w && (rd_w != '0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(rs1_q, RegWriteM, RdM, RegWriteW, RdW);
        ForwardBE = fwd_sel(rs2_q, RegWriteM, RdM, RegWriteW, RdW);
    end

    always_comb begin
        case (ForwardAE)
            2'b10:   SrcAE = AluResultM;
            2'b01:   SrcAE = ResultW;
            default: SrcAE = rd1_q;
        endcase
        case (ForwardBE)
            2'b10:   WriteDataE = AluResultM;
            2'b01:   WriteDataE = ResultW;
            default: WriteDataE = rd2_q;
        endcase
        SrcBE = alusrc_q ? imm_q : WriteDataE;
    end

    assign PCTargetE   = pc_q + imm_q;
    assign PCSrcE      = valid_q & (jump_q | (br_q & ZeroE));
    assign AluControlE = aluc_q;
    assign PCPlus4E    = pc4_q;
    assign RdE         = rd_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RegWriteE   = rw_q;
    assign MemWriteE   = mw_q;
    assign ResultSrcE  = rsrc_q;
    assign ValidE      = valid_q;

endmodule

// File: tb/tb_risc_id_ex_stage.sv
// tb/tb_risc_id_ex_stage.sv - randomized and directed checks of risc_id_ex_stage against a reference model
module tb_risc_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall_e, flush_e;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD, AluResultM, ResultW;
    logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, AluSrcD, RegWriteM, RegWriteW, ZeroE;
    logic [1:0]  ResultSrcD;
    logic [2:0]  AluControlD;
    logic [31:0] SrcAE, SrcBE, WriteDataE, PCTargetE, PCPlus4E;
    logic [2:0]  AluControlE;
    logic [4:0]  RdE, Rs1E, Rs2E;
    logic        RegWriteE, MemWriteE, PCSrcE, ValidE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    risc_id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .AluSrcD(AluSrcD), .ResultSrcD(ResultSrcD), .AluControlD(AluControlD),
        .AluResultM(AluResultM), .ResultW(ResultW), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ZeroE(ZeroE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .AluControlE(AluControlE), .WriteDataE(WriteDataE),
        .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ValidE(ValidE)
    );

    // Reference picture of the instruction currently sitting in E.
    typedef struct packed {
        logic [31:0] rd1, rd2, pc, pc4, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw, jump, br, alusrc, valid;
        logic [1:0]  rsrc;
        logic [2:0]  aluc;
    } e_t;

    e_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_operand(input logic [1:0] sel, input logic [31:0] reg_val);
        if (sel == 2'b10) return AluResultM;
        if (sel == 2'b01) return ResultW;
        return reg_val;
    endfunction

    task automatic check_all();
        logic [31:0] wd;
        wd = ref_operand(ref_fwd(m.rs2), m.rd2);
        chk("ForwardAE", {30'd0, ForwardAE}, {30'd0, ref_fwd(m.rs1)});
        chk("ForwardBE", {30'd0, ForwardBE}, {30'd0, ref_fwd(m.rs2)});
        chk("SrcAE", SrcAE, ref_operand(ref_fwd(m.rs1), m.rd1));
        chk("WriteDataE", WriteDataE, wd);
        chk("SrcBE", SrcBE, m.alusrc ? m.imm : wd);
        chk("PCTargetE", PCTargetE, m.pc + m.imm);
        chk("PCPlus4E", PCPlus4E, m.pc4);
        chk("AluControlE", {29'd0, AluControlE}, {29'd0, m.aluc});
        chk("RdE", {27'd0, RdE}, {27'd0, m.rd});
        chk("Rs1E", {27'd0, Rs1E}, {27'd0, m.rs1});
        chk("Rs2E", {27'd0, Rs2E}, {27'd0, m.rs2});
        chk("RegWriteE", {31'd0, RegWriteE}, {31'd0, m.rw});
        chk("MemWriteE", {31'd0, MemWriteE}, {31'd0, m.mw});
        chk("ResultSrcE", {30'd0, ResultSrcE}, {30'd0, m.rsrc});
        chk("ValidE", {31'd0, ValidE}, {31'd0, m.valid});
        chk("PCSrcE", {31'd0, PCSrcE}, {31'd0, m.valid & (m.jump | (m.br & ZeroE))});
    endtask

    // One clock: model captures at the edge the DUT does, outputs compared mid-cycle.
    task automatic cycle();
        @(posedge clk);
        if (flush_e) begin
            m.rw = 0; m.mw = 0; m.jump = 0; m.br = 0; m.valid = 0;
            m.rsrc = 0; m.aluc = 0; m.rs1 = 0; m.rs2 = 0; m.rd = 0;
        end else if (!stall_e) begin
            m = '{rd1: RD1D, rd2: RD2D, pc: PCD, pc4: PCPlus4D, imm: ImmExtD,
                  rs1: Rs1D, rs2: Rs2D, rd: RdD, rw: RegWriteD, mw: MemWriteD,
                  jump: JumpD, br: BranchD, alusrc: AluSrcD, valid: 1'b1,
                  rsrc: ResultSrcD, aluc: AluControlD};
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic randomize_inputs();
        RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
        Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3)); RdD = 5'($urandom);
        RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); JumpD = 1'($urandom_range(0, 3) == 0);
        BranchD = 1'($urandom); AluSrcD = 1'($urandom);
        ResultSrcD = 2'($urandom); AluControlD = 3'($urandom);
        AluResultM = $urandom; ResultW = $urandom;
        RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
        RegWriteM = 1'($urandom); RegWriteW = 1'($urandom); ZeroE = 1'($urandom);
    endtask

    task automatic clear_inputs();
        RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0; ImmExtD = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
        RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; AluSrcD = 0;
        ResultSrcD = 0; AluControlD = 0; AluResultM = 0; ResultW = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ZeroE = 0; stall_e = 0; flush_e = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        m = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
        chk("reset_ValidE", {31'd0, ValidE}, 32'd0);
        chk("reset_PCSrcE", {31'd0, PCSrcE}, 32'd0);

        // Plain load, no forwarding
        RD1D = 5; RD2D = 7; AluSrcD = 0; Rs1D = 1; Rs2D = 2;
        cycle();
        chk("load_SrcAE", SrcAE, 32'd5);
        chk("load_SrcBE", SrcBE, 32'd7);
        chk("load_WriteDataE", WriteDataE, 32'd7);
        chk("load_ValidE", {31'd0, ValidE}, 32'd1);

        // Forwarding priority MEM > WB, then x0 never forwarded
        Rs1D = 3;
        cycle();
        RdM = 3; RegWriteM = 1; AluResultM = 32'hAA; RdW = 3; RegWriteW = 1; ResultW = 32'hBB;
        #1;
        check_all();
        chk("fwd_mem_sel", {30'd0, ForwardAE}, 32'd2);
        chk("fwd_mem_SrcAE", SrcAE, 32'hAA);
        RegWriteM = 0;
        #1;
        chk("fwd_wb_SrcAE", SrcAE, 32'hBB);
        RdM = 0; RdW = 0; Rs1D = 0; RegWriteM = 1;
        cycle();
        chk("fwd_x0_sel", {30'd0, ForwardAE}, 32'd0);

        // Immediate operand with store data forwarded from MEM
        AluSrcD = 1; ImmExtD = 32'hFFFF_FFFC; Rs2D = 4; RdM = 4; RegWriteM = 1; AluResultM = 32'h1234;
        cycle();
        chk("imm_SrcBE", SrcBE, 32'hFFFF_FFFC);
        chk("imm_WriteDataE", WriteDataE, 32'h1234);

        // Branch resolution and target wrap
        RegWriteM = 0; PCD = 32'h100; ImmExtD = 32'h20; BranchD = 1; ZeroE = 1;
        cycle();
        chk("br_target", PCTargetE, 32'h120);
        chk("br_taken", {31'd0, PCSrcE}, 32'd1);
        ZeroE = 0;
        #1;
        chk("br_not_taken", {31'd0, PCSrcE}, 32'd0);
        PCD = 32'hFFFF_FFF0;
        cycle();
        chk("br_wrap", PCTargetE, 32'h10);

        // Stall holds through changing inputs; stall+flush bubbles
        BranchD = 0; RegWriteD = 1; MemWriteD = 1; RdD = 9; JumpD = 1;
        cycle();
        stall_e = 1;
        for (int i = 0; i < 2; i++) begin
            randomize_inputs();
            cycle();
            chk("stall_RdE", {27'd0, RdE}, 32'd9);
        end
        flush_e = 1;
        cycle();
        chk("flush_RegWriteE", {31'd0, RegWriteE}, 32'd0);
        chk("flush_MemWriteE", {31'd0, MemWriteE}, 32'd0);
        chk("flush_ValidE", {31'd0, ValidE}, 32'd0);
        chk("flush_PCSrcE", {31'd0, PCSrcE}, 32'd0);

        // Randomized traffic with occasional stalls and flushes
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            stall_e = ($urandom_range(0, 4) == 0);
            flush_e = ($urandom_range(0, 6) == 0);
            cycle();
        end

        // Asynchronous reset mid-cycle, while stalled, with a live instruction in E
        randomize_inputs();
        stall_e = 0; flush_e = 0; JumpD = 1;
        cycle();
        stall_e = 1;
        #2;
        rst_n = 1'b0;
        m = '0;
        #1;
        check_all();
        chk("arst_ValidE", {31'd0, ValidE}, 32'd0);
        chk("arst_PCSrcE", {31'd0, PCSrcE}, 32'd0);
        #1;
        rst_n = 1'b1;
        stall_e = 0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
